magic_nmi: RTL and testbench

Magic-button NMI controller, clocked by the CPU clock from the CPU clock/INT/reset generator and sitting directly downstream of it. It turns a front-panel button press into a Z80 NMI request and detects acknowledgement (opcode fetch from 0x0066). It overlays the magic ROM while the service routine runs, then releases the overlay on RETN or on a write to the exit port. The memory mapper consumes `magic_map`; the port decoder and OSD consume `magic_active`.

---
 rtl/magic_nmi_pkg.sv | 31 +++
 rtl/magic_nmi_fetch_detect.sv | 43 ++++
 rtl/magic_nmi.sv | 187 ++++++++++++++++++
 tb/tb_magic_nmi.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/magic_nmi_pkg.sv
// Shared definitions for the magic-button NMI controller.
//   NMI_VECTOR    : Z80 NMI entry address (acknowledge = opcode fetch here)
//   OPC_ED        : first byte of RETN
//   OPC_RETN2     : second byte of RETN
//   magic_state_t : controller state (IDLE, REQ, ACTIVE, HOLD)
//   cpu_bus_t     : the CPU bus signals observed by the controller,
//                   all active-high
package common;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;
    localparam logic [7:0]  OPC_ED     = 8'hED;
    localparam logic [7:0]  OPC_RETN2  = 8'h45;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } magic_state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        mreq;
        logic        iorq;
        logic        rd;
        logic        wr;
        logic        m1;
    } cpu_bus_t;

endpackage

// File: rtl/magic_nmi_fetch_detect.sv
// z80_fetch_detect: observes the fetch qualifier (m1 & mreq & rd) and
// reports completed opcode fetches.
//   clkcpu, rst_n : CPU clock, async active-low reset
//   fq            : fetch qualifier
//   d             : data bus
//   a             : address bus
//   fetch_done    : one-cycle pulse on the posedge where fq falls
//   opcode        : last data byte sampled while fq was high
//   at_vector     : address of that fetch was NMI_VECTOR
module z80_fetch_detect
    import common::*;
(
    input  logic        clkcpu,
    input  logic        rst_n,
    input  logic        fq,
    input  logic [7:0]  d,
    input  logic [15:0] a,
    output logic        fetch_done,
    output logic [7:0]  opcode,
    output logic        at_vector
);

    logic fq_q;

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            fq_q      <= 1'b0;
            opcode    <= 8'h00;
            at_vector <= 1'b0;
        end else begin
            fq_q <= fq;
            // Resample on every fq cycle so the value left behind is the
            // one present at the end of the fetch.
            if (fq) begin
                opcode    <= d;
                at_vector <= (a == NMI_VECTOR);
            end
        end
    end

    assign fetch_done = fq_q & ~fq;

endmodule

// File: rtl/magic_nmi.sv
// magic_nmi: front-panel magic button -> Z80 NMI, magic ROM overlay while
// the service routine runs.
//   clkcpu, rst_n : CPU clock, async active-low reset
//   bus           : observed CPU bus (a, d, mreq, iorq, rd, wr, m1)
//   magic_button  : asynchronous button level
//   n_int         : CPU INT line; NMI requests wait while it is low
//   n_rstcpu      : CPU reset, forces HOLD on the next posedge
//   n_nmi         : NMI to the CPU, active-low
//   magic_map     : overlay magic ROM at 0x0000-0x3FFF
//   magic_active  : session in progress
//   dbg_state     : current controller state
// Build option MAGIC_RETN_EXIT_EN: when defined, a RETN (ED 45) fetched in
// ACTIVE also ends the session; otherwise only the exit-port write does.
// Bus handshake: the block never stalls the CPU; it only observes bus
// strobes and acts on the posedges at which they are sampled high.
module magic_nmi
    import common::*;
#(
    parameter logic [7:0] EXIT_PORT   = 8'hFF,
    parameter int         NMI_TIMEOUT = 1023
) (
    input  logic         rst_n,
    input  logic         clkcpu,
    input  cpu_bus_t     bus,
    input  logic         magic_button,
    input  logic         n_int,
    input  logic         n_rstcpu,
    output logic         n_nmi,
    output logic         magic_map,
    output logic         magic_active,
    output magic_state_t dbg_state
);

    localparam int CNT_W = $clog2(NMI_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(NMI_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(NMI_TIMEOUT - 1);

    magic_state_t     state, state_n;
    logic             armed, armed_n;
    logic             pending, pending_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             btn_s1, btn_sync, btn_q;
    logic             trig;
    logic             fq, fetch_done, at_vector;
    logic [7:0]       opcode;
    logic             exit_wr;

    // Button: two-flop synchronizer plus edge register.
    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= 1'b0;
            btn_sync <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            btn_s1   <= magic_button;
            btn_sync <= btn_s1;
            btn_q    <= btn_sync;
        end
    end

    assign trig = btn_sync & ~btn_q & armed & (state == IDLE);

    assign fq = bus.m1 & bus.mreq & bus.rd;
    assign exit_wr = bus.iorq & bus.wr & ~bus.m1 & (bus.a[7:0] == EXIT_PORT);

    z80_fetch_detect u_fetch (
        .clkcpu     (clkcpu),
        .rst_n      (rst_n),
        .fq         (fq),
        .d          (bus.d),
        .a          (bus.a),
        .fetch_done (fetch_done),
        .opcode     (opcode),
        .at_vector  (at_vector)
    );

`ifdef MAGIC_RETN_EXIT_EN
    logic ed_seen, ed_seen_n;
`else
    logic unused_opcode;
    assign unused_opcode = ^opcode;
`endif

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            armed   <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
`ifdef MAGIC_RETN_EXIT_EN
            ed_seen <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            armed   <= armed_n;
            pending <= pending_n;
            cnt     <= cnt_n;
`ifdef MAGIC_RETN_EXIT_EN
            ed_seen <= ed_seen_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        armed_n   = armed;
        pending_n = pending;
        cnt_n     = cnt;
`ifdef MAGIC_RETN_EXIT_EN
        ed_seen_n = ed_seen;
`endif

        // Re-arm only once the button is seen released while idle/holding,
        // so one long press cannot fire twice.
        if (trig)
            armed_n = 1'b0;
        else if ((state == IDLE || state == HOLD) && !btn_sync)
            armed_n = 1'b1;

        case (state)
            IDLE: begin
                if ((trig || pending) && n_int) begin
                    state_n   = REQ;
                    pending_n = 1'b0;
                    cnt_n     = '0;
                end else if (trig) begin
                    pending_n = 1'b1;
                end
            end
            REQ: begin
                if (cnt != CNT_MAX)
                    cnt_n = cnt + 1'b1;
                // Acknowledge wins over a timeout on the same edge. The
                // timeout fires on the edge where the count reaches
                // NMI_TIMEOUT, so n_nmi is low for exactly that many cycles.
                if (fetch_done && at_vector)
                    state_n = ACTIVE;
                else if (cnt == TIMEOUT_LAST)
                    state_n = HOLD;
            end
            ACTIVE: begin
                if (exit_wr)
                    state_n = HOLD;
`ifdef MAGIC_RETN_EXIT_EN
                if (fetch_done) begin
                    if (opcode == OPC_ED) begin
                        ed_seen_n = 1'b1;
                    end else if (ed_seen && opcode == OPC_RETN2) begin
                        state_n   = HOLD;
                        ed_seen_n = 1'b0;
                    end else begin
                        ed_seen_n = 1'b0;
                    end
                end
`endif
            end
            HOLD: begin
                if (!btn_sync)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

`ifdef MAGIC_RETN_EXIT_EN
        if (state_n != ACTIVE)
            ed_seen_n = 1'b0;
`endif

        if (!n_rstcpu) begin
            state_n   = HOLD;
            pending_n = 1'b0;
            cnt_n     = '0;
`ifdef MAGIC_RETN_EXIT_EN
            ed_seen_n = 1'b0;
`endif
        end
    end

    assign n_nmi        = (state != REQ);
    assign magic_active = (state == ACTIVE);
    // The REQ term lets the very first opcode at the NMI vector come from
    // magic ROM, before the registered state has moved to ACTIVE.
    assign magic_map    = (state == ACTIVE) ||
                          (state == REQ && fq && bus.a == NMI_VECTOR);
    assign dbg_state    = state;

endmodule

// File: tb/tb_magic_nmi.sv
// Directed testbench for magic_nmi.
module tb_magic_nmi;
    import common::*;

    logic         rst_n;
    logic         clkcpu;
    cpu_bus_t     bus;
    logic         magic_button;
    logic         n_int;
    logic         n_rstcpu;
    logic         n_nmi;
    logic         magic_map;
    logic         magic_active;
    magic_state_t dbg_state;

    int errors = 0;
    int checks = 0;

    magic_nmi dut (
        .rst_n        (rst_n),
        .clkcpu       (clkcpu),
        .bus          (bus),
        .magic_button (magic_button),
        .n_int        (n_int),
        .n_rstcpu     (n_rstcpu),
        .n_nmi        (n_nmi),
        .magic_map    (magic_map),
        .magic_active (magic_active),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clkcpu = 1'b0;
    always #5 clkcpu = ~clkcpu;

    task automatic tick();
        @(posedge clkcpu);
        #1;
    endtask

    // drivers
    task automatic bus_idle();
        bus = '0;
    endtask

    // Opcode fetch: two posedges with fq high, completion on the third.
    task automatic fetch(input logic [15:0] addr, input logic [7:0] data,
                         output logic map_seen);
        bus      = '0;
        bus.a    = addr;
        bus.d    = data;
        bus.m1   = 1'b1;
        bus.mreq = 1'b1;
        bus.rd   = 1'b1;
        #1;
        map_seen = magic_map;
        tick();
        tick();
        bus_idle();
        tick();
    endtask

    task automatic io_write(input logic [15:0] addr);
        bus      = '0;
        bus.a    = addr;
        bus.iorq = 1'b1;
        bus.wr   = 1'b1;
        tick();
        bus_idle();
        #1;
    endtask

    // Press, wait for the request, release, acknowledge at the vector.
    task automatic enter_active();
        logic m;
        magic_button = 1'b1;
        repeat (3) tick();
        magic_button = 1'b0;
        fetch(16'h0066, 8'hF5, m);
    endtask

    task automatic leave_to_idle();
        io_write(16'h00FF);
        repeat (4) tick();
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        n_rstcpu = 1'b1;
        n_int = 1'b1;
        magic_button = 1'b0;
        bus_idle();
        #1;
        checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL reset_n_nmi got=%b exp=1", n_nmi); end
        checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL reset_map got=%b exp=0", magic_map); end
        checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", magic_active); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        #12 rst_n = 1'b1;
        tick(); tick();
        // A vector-address fetch in IDLE must not map the ROM.
        bus.a = 16'h0066; bus.m1 = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
        #1;
        checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL idle_vector_map got=%b exp=0", magic_map); end
        bus_idle();
        tick(); tick();
    endtask

    task automatic test_trigger();
        logic m;
        magic_button = 1'b1;
        tick();
        checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL trig_edge1 got=%b exp=1", n_nmi); end
        tick();
        checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL trig_edge2 got=%b exp=1", n_nmi); end
        tick();
        checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL trig_edge3 got=%b exp=0", n_nmi); end
        checks++; if (dbg_state !== REQ) begin errors++; $display("FAIL trig_state got=%0d exp=%0d", dbg_state, REQ); end
        // Button stays held through the whole session.
        fetch(16'h0066, 8'hF5, m);
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL ack_fetch_map got=%b exp=1", m); end
        checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL ack_n_nmi got=%b exp=1", n_nmi); end
        checks++; if (magic_active !== 1'b1) begin errors++; $display("FAIL ack_active got=%b exp=1", magic_active); end
        checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL ack_map got=%b exp=1", magic_map); end
    endtask

    task automatic test_exit_port();
        io_write(16'h12FF);
        checks++; if (dbg_state !== HOLD) begin errors++; $display("FAIL exit_state got=%0d exp=%0d", dbg_state, HOLD); end
        checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL exit_map got=%b exp=0", magic_map); end
        repeat (3) tick();
        checks++; if (dbg_state !== HOLD) begin errors++; $display("FAIL hold_held got=%0d exp=%0d", dbg_state, HOLD); end
        magic_button = 1'b0;
        repeat (3) tick();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL hold_release got=%0d exp=%0d", dbg_state, IDLE); end
        // Re-armed: a fresh press requests again after 3 posedges.
        magic_button = 1'b1;
        repeat (3) tick();
        checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL rearm_n_nmi got=%b exp=0", n_nmi); end
        magic_button = 1'b0;
        begin
            logic m;
            fetch(16'h0066, 8'h00, m);
        end
        leave_to_idle();
    endtask

    task automatic test_int_pending();
        logic stayed_high;
        n_int = 1'b0;
        magic_button = 1'b1;
        stayed_high = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_nmi !== 1'b1) stayed_high = 1'b0;
        end
        checks++; if (stayed_high !== 1'b1) begin errors++; $display("FAIL int_low_hold got=%b exp=1", stayed_high); end
        magic_button = 1'b0;
        n_int = 1'b1;
        tick();
        checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL int_release got=%b exp=0", n_nmi); end
        begin
            logic m;
            fetch(16'h0066, 8'h00, m);
        end
        leave_to_idle();
    endtask

    task automatic test_retn();
        logic m;
        magic_state_t exp_st;
`ifdef MAGIC_RETN_EXIT_EN
        exp_st = HOLD;
`else
        exp_st = ACTIVE;
`endif
        enter_active();
        fetch(16'h1000, 8'hED, m);
        fetch(16'h1001, 8'h45, m);
        checks++; if (dbg_state !== exp_st) begin errors++; $display("FAIL retn_ed45 got=%0d exp=%0d", dbg_state, exp_st); end
        checks++; if (magic_map !== (exp_st == ACTIVE)) begin errors++; $display("FAIL retn_map got=%b exp=%b", magic_map, exp_st == ACTIVE); end
        leave_to_idle();
        enter_active();
        fetch(16'h1000, 8'hED, m);
        fetch(16'h1001, 8'h00, m);
        fetch(16'h1002, 8'h45, m);
        checks++; if (dbg_state !== ACTIVE) begin errors++; $display("FAIL retn_ed0045 got=%0d exp=%0d", dbg_state, ACTIVE); end
        leave_to_idle();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL retn_back_idle got=%0d exp=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_timeout();
        int low_cycles;
        logic map_seen;
        magic_button = 1'b1;
        repeat (3) tick();
        magic_button = 1'b0;
        checks++; if (n_nmi !== 1'b0) begin errors++; $display("FAIL to_start got=%b exp=0", n_nmi); end
        low_cycles = 0;
        map_seen = 1'b0;
        while (n_nmi === 1'b0 && low_cycles < 2000) begin
            tick();
            low_cycles++;
            if (magic_map !== 1'b0) map_seen = 1'b1;
        end
        checks++; if (low_cycles != 1023) begin errors++; $display("FAIL to_cycles got=%0d exp=1023", low_cycles); end
        checks++; if (dbg_state !== HOLD) begin errors++; $display("FAIL to_state got=%0d exp=%0d", dbg_state, HOLD); end
        checks++; if (map_seen !== 1'b0) begin errors++; $display("FAIL to_map got=%b exp=0", map_seen); end
        tick();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL to_idle got=%0d exp=%0d", dbg_state, IDLE); end
        tick();
    endtask

    task automatic test_rstcpu();
        enter_active();
        n_rstcpu = 1'b0;
        #1;
        checks++; if (magic_map !== 1'b1) begin errors++; $display("FAIL rstcpu_before got=%b exp=1", magic_map); end
        tick();
        checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL rstcpu_map got=%b exp=0", magic_map); end
        checks++; if (dbg_state !== HOLD) begin errors++; $display("FAIL rstcpu_state got=%0d exp=%0d", dbg_state, HOLD); end
        n_rstcpu = 1'b1;
        tick();
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rstcpu_idle got=%0d exp=%0d", dbg_state, IDLE); end
        tick();
    endtask

    task automatic test_async_reset();
        magic_button = 1'b1;
        repeat (3) tick();
        magic_button = 1'b0;
        checks++; if (dbg_state !== REQ) begin errors++; $display("FAIL ar_req got=%0d exp=%0d", dbg_state, REQ); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (n_nmi !== 1'b1) begin errors++; $display("FAIL ar_n_nmi got=%b exp=1", n_nmi); end
        checks++; if (magic_map !== 1'b0) begin errors++; $display("FAIL ar_map got=%b exp=0", magic_map); end
        checks++; if (magic_active !== 1'b0) begin errors++; $display("FAIL ar_active got=%b exp=0", magic_active); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL ar_state got=%0d exp=%0d", dbg_state, IDLE); end
        #10 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_exit_port();
        test_int_pending();
        test_retn();
        test_timeout();
        test_rstcpu();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
